// File: rtl/fifo.sv
// Single-clock byte FIFO between the UART paths and the memory controller.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [ADDR_WIDTH:0] wr_ptr;
   logic [ADDR_WIDTH:0] rd_ptr;
   logic                wr_ok;
   logic                rd_ok;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                  (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         dout   <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            dout   <= mem[rd_ptr[ADDR_WIDTH-1:0]];
         end
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo against a queue-based reference model.
// Error-flag expectations follow FIFO_ERR_FLAGS_EN when it is defined.
module tb_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             wr_en = 1'b0;
   logic             rd_en = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] dout;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] q [$];
   logic [WIDTH-1:0] exp_dout = '0;
   logic             exp_ovf  = 1'b0;
   logic             exp_unf  = 1'b0;

   fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .din       (din),
      .full      (full),
      .rd_en     (rd_en),
      .dout      (dout),
      .empty     (empty),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   // Drive one clock edge and advance the model by the same rules.
   task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
      bit w_ok, r_ok;
      w_ok = w && (q.size() < DEPTH);
      r_ok = r && (q.size() > 0);
      if (w && q.size() == DEPTH) exp_ovf = 1'b1;
      if (r && q.size() == 0) exp_unf = 1'b1;
      if (r_ok) exp_dout = q.pop_front();
      if (w_ok) q.push_back(d);
      wr_en = w;
      rd_en = r;
      din   = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic model_reset();
      q.delete();
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
   endtask

   function automatic logic flag_exp(input logic f);
`ifdef FIFO_ERR_FLAGS_EN
      return f;
`else
      return 1'b0;
`endif
   endfunction

   task automatic drain();
      while (q.size() > 0) cycle(1'b0, 1'b1, '0);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      total++;
      if (empty !== 1'b1 || full !== 1'b0 || dout !== '0) begin
         bad++;
         $display("FAIL reset_state got e=%b f=%b d=%h want e=1 f=0 d=00",
                  empty, full, dout);
      end
      total++;
      if (overflow !== 1'b0 || underflow !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags got o=%b u=%b want 0 0", overflow, underflow);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] vals [3];
      vals = '{8'h11, 8'h22, 8'h33};
      foreach (vals[i]) cycle(1'b1, 1'b0, vals[i]);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, '0);
         total++;
         if (dout !== vals[i] || dout !== exp_dout) begin
            bad++;
            $display("FAIL basic_read%0d got=%h want=%h", i, dout, vals[i]);
         end
      end
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL basic_empty got=%b want=1", empty);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if (full !== 1'b0) begin
            bad++;
            $display("FAIL fill_early_full at %0d got=%b want=0", i, full);
         end
         cycle(1'b1, 1'b0, WIDTH'(i));
      end
      total++;
      if (full !== 1'b1 || empty !== 1'b0) begin
         bad++;
         $display("FAIL fill_full got f=%b e=%b want f=1 e=0", full, empty);
      end
      cycle(1'b1, 1'b0, 8'hAA);
      total++;
      if (full !== 1'b1 || overflow !== flag_exp(exp_ovf)) begin
         bad++;
         $display("FAIL fill_overflow got f=%b o=%b want f=1 o=%b",
                  full, overflow, flag_exp(exp_ovf));
      end
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 1'b1, '0);
         total++;
         if (dout !== WIDTH'(i) || dout !== exp_dout) begin
            bad++;
            $display("FAIL fill_order%0d got=%h want=%h", i, dout, WIDTH'(i));
         end
      end
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL fill_drained got=%b want=1", empty);
      end
   endtask

   task automatic test_underflow();
      logic [WIDTH-1:0] prev;
      prev = dout;
      cycle(1'b0, 1'b1, '0);
      total++;
      if (dout !== prev || empty !== 1'b1 || underflow !== flag_exp(exp_unf)) begin
         bad++;
         $display("FAIL underflow_read got d=%h e=%b u=%b want d=%h e=1 u=%b",
                  dout, empty, underflow, prev, flag_exp(exp_unf));
      end
      cycle(1'b1, 1'b1, 8'h5A);
      total++;
      if (empty !== 1'b0 || dout !== prev) begin
         bad++;
         $display("FAIL underflow_simul got e=%b d=%h want e=0 d=%h",
                  empty, dout, prev);
      end
      cycle(1'b0, 1'b1, '0);
      total++;
      if (dout !== 8'h5A || empty !== 1'b1) begin
         bad++;
         $display("FAIL underflow_5a got d=%h e=%b want d=5a e=1", dout, empty);
      end
   endtask

   task automatic test_back_to_back();
      int k;
      int errs;
      for (k = 0; k < 4; k++) cycle(1'b1, 1'b0, WIDTH'(k));
      errs = 0;
      for (int i = 0; i < 100; i++) begin
         cycle(1'b1, 1'b1, WIDTH'(k));
         k++;
         total++;
         if (dout !== WIDTH'(i) || empty !== 1'b0 || full !== 1'b0) begin
            bad++;
            errs++;
            if (errs < 5)
               $display("FAIL stream%0d got d=%h e=%b f=%b want d=%h e=0 f=0",
                        i, dout, empty, full, WIDTH'(i));
         end
      end
      drain();
      total++;
      if (dout !== WIDTH'(103) || empty !== 1'b1) begin
         bad++;
         $display("FAIL stream_tail got d=%h e=%b want d=67 e=1", dout, empty);
      end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, WIDTH'(8'hC0 + i));
      cycle(1'b1, 1'b1, 8'h77);
      total++;
      if (dout !== 8'hC0 || full !== 1'b0) begin
         bad++;
         $display("FAIL fullsim got d=%h f=%b want d=c0 f=0", dout, full);
      end
      for (int i = 1; i < DEPTH; i++) begin
         cycle(1'b0, 1'b1, '0);
         total++;
         if (dout !== WIDTH'(8'hC0 + i) || dout === 8'h77) begin
            bad++;
            $display("FAIL fullsim_drain%0d got=%h want=%h", i, dout, WIDTH'(8'hC0 + i));
         end
      end
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL fullsim_empty got=%b want=1", empty);
      end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 600; i++) begin
         int bias;
         bias = ((i / 60) % 2 == 0) ? 75 : 25;
         cycle(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) >= bias),
               WIDTH'($urandom));
         total++;
         if (dout !== exp_dout || empty !== (q.size() == 0) ||
             full !== (q.size() == DEPTH) ||
             overflow !== flag_exp(exp_ovf) || underflow !== flag_exp(exp_unf)) begin
            bad++;
            errs++;
            if (errs < 5)
               $display("FAIL random%0d got d=%h e=%b f=%b o=%b u=%b want d=%h n=%0d",
                        i, dout, empty, full, overflow, underflow, exp_dout, q.size());
         end
      end
      drain();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, WIDTH'(8'h81 + i));
      cycle(1'b0, 1'b1, '0);
      total++;
      if (dout !== 8'h81) begin
         bad++;
         $display("FAIL arst_pre got=%h want=81", dout);
      end
      rd_en = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (empty !== 1'b1 || full !== 1'b0 || dout !== '0) begin
         bad++;
         $display("FAIL arst_now got e=%b f=%b d=%h want e=1 f=0 d=00",
                  empty, full, dout);
      end
      total++;
      if (overflow !== 1'b0 || underflow !== 1'b0) begin
         bad++;
         $display("FAIL arst_flags got o=%b u=%b want 0 0", overflow, underflow);
      end
      rd_en = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b1, 1'b0, 8'hE5);
      cycle(1'b0, 1'b1, '0);
      total++;
      if (dout !== 8'hE5 || empty !== 1'b1) begin
         bad++;
         $display("FAIL arst_new got d=%h e=%b want d=e5 e=1", dout, empty);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_underflow();
      test_back_to_back();
      test_full_simul();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock FIFO that buffers bytes between the UART receive path and the memory controller (RX direction), and between the memory controller and the UART transmit path (TX direction).
- It directly feeds the controller's rx_fifo_rd_en / rx_fifo_empty / din interface, and it consumes the controller's tx_fifo_wr_en / tx_fifo_full / dout interface.
- Storage is a register array. Reads are registered: data appears the cycle after the read is accepted.

Parameters:
- WIDTH, 8, bits per entry.
- DEPTH, 32, number of entries; must be a power of 2 and >= 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer index width; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset; asserting it (0) immediately clears all state.
- wr_en  input  1  write request.
- din  input  WIDTH  write data, sampled with wr_en.
- full  output  1  no free entries.
- rd_en  input  1  read request.
- dout  output  WIDTH  read data, registered.
- empty  output  1  no valid entries.
- overflow  output  1  sticky; write attempted while full (optional feature).
- underflow  output  1  sticky; read attempted while empty (optional feature).

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, rd_ptr=0, dout=0, empty=1, full=0, overflow=0, underflow=0. Array contents are don't-care.
- Pointers are ADDR_WIDTH+1 bits. The array index is the low ADDR_WIDTH bits; the pointers wrap naturally at 2*DEPTH.
- empty = (wr_ptr == rd_ptr).
- full = (low bits equal) and (MSBs differ).
- Both flags are combinational from the registered pointers. They reflect an accepted operation on the cycle after its edge.
- Write accepted iff wr_en=1 and full=0. On acceptance:
  - mem[wr_ptr] <= din.
  - wr_ptr <= wr_ptr+1.
- Read accepted iff rd_en=1 and empty=0. On acceptance:
  - dout <= mem[rd_ptr].
  - rd_ptr <= rd_ptr+1.
  - Read latency is 1 cycle: dout is valid in the cycle after the edge where rd_en was high with empty low.
- dout holds its last value when no read is accepted.
- Rejected operations (write when full, read when empty) change no pointer and no data.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both accepted; occupancy unchanged; full and empty unchanged.
  - Empty: only the write is accepted; the read is rejected (no fall-through); empty deasserts next cycle.
  - Full: only the read is accepted; the write is dropped; full deasserts next cycle.
- Pointer wrap: after DEPTH writes and DEPTH reads the index returns to 0. Ordering is preserved across the wrap.
- Reset mid-operation: an in-flight read is abandoned, dout goes to 0, and all buffered data is discarded.
- Occupancy never exceeds DEPTH.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on any edge with wr_en=1 and full=1.
  - underflow sets on any edge with rd_en=1 and empty=1.
  - Both are sticky and cleared only by reset.
- Not defined: overflow and underflow are tied to 0 and no flag registers are built.
- FIFO data behaviour is identical either way.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33; read 3 times -> dout = 0x11, 0x22, 0x33 on the cycle after each read; empty=1 after the third read.
- Write 32 values 0x00..0x1F -> full=1 after the 32nd write. A 33rd write of 0xAA is ignored (overflow=1 with macro). Read 32 -> 0x00..0x1F in order; 0xAA never appears.
- At empty, read once -> dout keeps its previous value, pointers unchanged (underflow=1 with macro). Same cycle wr_en=1 din=0x5A -> empty=0 next cycle; the next read returns 0x5A.
- Hold occupancy at 4 and drive wr_en=rd_en=1 for 100 cycles with an incrementing pattern (pointers wrap 3+ times) -> output sequence equals input sequence delayed by 4; flags never toggle.
- At full, assert wr_en=rd_en=1 with din=0x77 -> read returns the oldest entry; 0x77 is not stored; full=0 next cycle.
- With 5 entries queued, pull rst low between clock edges -> empty=1, full=0, dout=0 immediately (before the next edge); after release, the first write/read returns the new data only.
